// File: rtl/tlb_op_sched.sv
// Sequences TLB maintenance ops (TLBRD/TLBWR/TLBFILL/INVTLB from WB, TLBSRCH from EXE)
// onto a single TLB read/write/search port set, one operation at a time.
module tlb_op_sched #(
    parameter int TLBNUM = 16,
    localparam int IDXW = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            wb_req_valid,
    input  logic [1:0]      wb_req_op,
    input  logic [4:0]      wb_inv_op,
    input  logic [9:0]      wb_inv_asid,
    input  logic [18:0]     wb_inv_vppn,
    output logic            wb_req_ready,
    output logic            wb_done,
    input  logic            ex_srch_valid,
    output logic            ex_srch_ready,
    output logic            ex_srch_done,
    output logic            ex_srch_found,
    output logic [IDXW-1:0] ex_srch_index,
    input  logic            wb_write_asid_ehi,
    input  logic            flush,
    input  logic [IDXW-1:0] csr_tlbidx_index,
    output logic            tlb_s_req,
    input  logic            tlb_s_found,
    input  logic [IDXW-1:0] tlb_s_index,
    output logic [IDXW-1:0] tlb_r_index,
    input  logic            tlb_r_e,
    input  logic            tlb_r_g,
    input  logic [9:0]      tlb_r_asid,
    input  logic [18:0]     tlb_r_vppn,
    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output logic            tlb_inv_clr,
    output logic            busy,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SRCH = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        INV  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic [4:0]      inv_op_q;
    logic [9:0]      inv_asid_q;
    logic [18:0]     inv_vppn_q;
    logic [IDXW-1:0] fill_ctr;
    logic [IDXW-1:0] scan_ctr;
    logic            inv_armed;
    logic            asid_eq;
    logic            vppn_eq;
    logic            inv_hit;
    logic            scan_last;

    // Handshake: a request is taken on the rising edge where its valid and ready are
    // both high. Ready is combinational and only ever high in IDLE; WB wins over EXE.
    assign wb_req_ready  = resetn & (state == IDLE) & wb_req_valid;
    assign ex_srch_ready = resetn & (state == IDLE) & ~wb_req_valid & ~wb_write_asid_ehi
                         & ~flush & ex_srch_valid;

    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign scan_last = (scan_ctr == IDXW'(TLBNUM - 1));

    always_comb begin
        tlb_r_index = '0;
        if (state == RD)
            tlb_r_index = csr_tlbidx_index;
        else if (state == INV)
            tlb_r_index = scan_ctr;
    end

    assign tlb_w_index = (state != WR) ? '0 : (op_q == 2'd2) ? fill_ctr : csr_tlbidx_index;

    always_comb begin
        asid_eq = (tlb_r_asid == inv_asid_q);
        vppn_eq = (tlb_r_vppn == inv_vppn_q);
        case (inv_op_q)
            5'd0, 5'd1: inv_hit = 1'b1;
            5'd2:       inv_hit = tlb_r_g;
            5'd3:       inv_hit = ~tlb_r_g;
            5'd4:       inv_hit = ~tlb_r_g & asid_eq;
            5'd5:       inv_hit = ~tlb_r_g & asid_eq & vppn_eq;
            5'd6:       inv_hit = (tlb_r_g | asid_eq) & vppn_eq;
            default:    inv_hit = 1'b0;
        endcase
    end

    // The read port is only meaningful once the scan is armed; the first INV cycle
    // just screens the op code so an illegal op never touches an entry.
    assign tlb_inv_clr = (state == INV) & inv_armed & tlb_r_e & inv_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            op_q          <= '0;
            inv_op_q      <= '0;
            inv_asid_q    <= '0;
            inv_vppn_q    <= '0;
            fill_ctr      <= '0;
            scan_ctr      <= '0;
            inv_armed     <= 1'b0;
            tlb_we        <= 1'b0;
            tlb_s_req     <= 1'b0;
            wb_done       <= 1'b0;
            ex_srch_done  <= 1'b0;
            ex_srch_found <= 1'b0;
            ex_srch_index <= '0;
        end else begin
            fill_ctr     <= fill_ctr + 1'b1;
            tlb_we       <= 1'b0;
            tlb_s_req    <= 1'b0;
            wb_done      <= 1'b0;
            ex_srch_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_req_ready) begin
                        op_q       <= wb_req_op;
                        inv_op_q   <= wb_inv_op;
                        inv_asid_q <= wb_inv_asid;
                        inv_vppn_q <= wb_inv_vppn;
                        case (wb_req_op)
                            2'd0:       state <= RD;
                            2'd1, 2'd2: begin
                                state  <= WR;
                                tlb_we <= 1'b1;
                            end
                            default:    state <= INV;
                        endcase
                    end else if (ex_srch_ready) begin
                        state     <= SRCH;
                        tlb_s_req <= 1'b1;
                    end
                end
                SRCH: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        ex_srch_found <= tlb_s_found;
                        ex_srch_index <= tlb_s_index;
                        ex_srch_done  <= 1'b1;
                        state         <= DONE;
                    end
                end
                RD, WR: begin
                    wb_done <= 1'b1;
                    state   <= DONE;
                end
                INV: begin
                    if (!inv_armed) begin
                        if (inv_op_q > 5'd6) begin
                            wb_done <= 1'b1;
                            state   <= DONE;
                        end else begin
                            inv_armed <= 1'b1;
                        end
                    end else if (scan_last) begin
                        inv_armed <= 1'b0;
                        scan_ctr  <= '0;
                        wb_done   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        scan_ctr <= scan_ctr + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_op_sched.sv
// Directed plus randomized bench for tlb_op_sched with a small TLB array model
// that serves the combinational read port and predicts INVTLB clears.
module tb_tlb_op_sched;
    localparam int TLBNUM = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wb_req_valid = 1'b0;
    logic [1:0]  wb_req_op = '0;
    logic [4:0]  wb_inv_op = '0;
    logic [9:0]  wb_inv_asid = '0;
    logic [18:0] wb_inv_vppn = '0;
    logic        wb_req_ready, wb_done;
    logic        ex_srch_valid = 1'b0;
    logic        ex_srch_ready, ex_srch_done, ex_srch_found;
    logic [3:0]  ex_srch_index;
    logic        wb_write_asid_ehi = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  csr_tlbidx_index = '0;
    logic        tlb_s_req;
    logic        tlb_s_found = 1'b0;
    logic [3:0]  tlb_s_index = '0;
    logic [3:0]  tlb_r_index;
    logic        tlb_r_e, tlb_r_g;
    logic [9:0]  tlb_r_asid;
    logic [18:0] tlb_r_vppn;
    logic        tlb_we;
    logic [3:0]  tlb_w_index;
    logic        tlb_inv_clr, busy;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    tlb_op_sched #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .resetn(resetn),
        .wb_req_valid(wb_req_valid), .wb_req_op(wb_req_op), .wb_inv_op(wb_inv_op),
        .wb_inv_asid(wb_inv_asid), .wb_inv_vppn(wb_inv_vppn),
        .wb_req_ready(wb_req_ready), .wb_done(wb_done),
        .ex_srch_valid(ex_srch_valid), .ex_srch_ready(ex_srch_ready),
        .ex_srch_done(ex_srch_done), .ex_srch_found(ex_srch_found), .ex_srch_index(ex_srch_index),
        .wb_write_asid_ehi(wb_write_asid_ehi), .flush(flush), .csr_tlbidx_index(csr_tlbidx_index),
        .tlb_s_req(tlb_s_req), .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
        .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_g(tlb_r_g),
        .tlb_r_asid(tlb_r_asid), .tlb_r_vppn(tlb_r_vppn),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_inv_clr(tlb_inv_clr),
        .busy(busy), .dbg_state(dbg_state)
    );

    // TLB contents, only ever written by the stimulus process
    logic        te[TLBNUM];
    logic        tg[TLBNUM];
    logic [9:0]  tasid[TLBNUM];
    logic [18:0] tvppn[TLBNUM];

    always_comb begin
        tlb_r_e    = te[tlb_r_index];
        tlb_r_g    = tg[tlb_r_index];
        tlb_r_asid = tasid[tlb_r_index];
        tlb_r_vppn = tvppn[tlb_r_index];
    end

    // cycles since reset release: the fill counter must equal this modulo TLBNUM
    int unsigned cyc;
    always @(posedge clk or negedge resetn)
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;

    int excl_viol = 0;
    always @(negedge clk)
        if (int'(tlb_we) + int'(tlb_s_req) + int'(tlb_inv_clr) > 1) excl_viol++;

    int          tests = 0;
    int          fails = 0;
    logic [4:0]  exp_q[$];
    logic [3:0]  clr_obs[$];
    logic        exp_found = 1'b0;
    logic [3:0]  exp_idx = '0;
    logic [3:0]  last_fill = '0;
    bit          have_fill = 0;
    bit          wrap_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_match(input int i, input logic [4:0] op,
                                       input logic [9:0] asid, input logic [18:0] vppn);
        bit a, v, g;
        a = (tasid[i] == asid);
        v = (tvppn[i] == vppn);
        g = tg[i];
        if (!te[i]) return 0;
        case (op)
            5'd0, 5'd1: return 1;
            5'd2:       return g;
            5'd3:       return !g;
            5'd4:       return !g && a;
            5'd5:       return !g && a && v;
            5'd6:       return (g || a) && v;
            default:    return 0;
        endcase
    endfunction

    task automatic rand_table;
        for (int i = 0; i < TLBNUM; i++) begin
            te[i]    = ($urandom_range(0, 3) != 0);
            tg[i]    = 1'($urandom_range(0, 1));
            tasid[i] = 10'($urandom_range(1, 3));
            tvppn[i] = 19'h100 + 19'($urandom_range(0, 1));
        end
    endtask

    // one WB op from accept to the cycle after its done pulse
    task automatic do_wb(input logic [1:0] op, input logic [3:0] idx, input logic [4:0] iop,
                         input logic [9:0] asid, input logic [18:0] vppn);
        int lat;
        logic [4:0] e;
        exp_q.delete();
        clr_obs.delete();
        if (op == 2'd3)
            for (int i = 0; i < TLBNUM; i++)
                if (model_match(i, iop, asid, vppn)) exp_q.push_back(5'(i));
        wb_req_valid = 1'b1; wb_req_op = op; wb_inv_op = iop;
        wb_inv_asid = asid; wb_inv_vppn = vppn; csr_tlbidx_index = idx;
        @(negedge clk);
        chk("wb_ready", wb_req_ready, 1);
        tick;
        wb_req_valid = 1'b0;
        wb_req_op = 2'($urandom); wb_inv_op = 5'($urandom);
        wb_inv_asid = 10'($urandom); wb_inv_vppn = 19'($urandom);
        if (op != 2'd3) begin
            @(negedge clk);
            chk("op_busy", busy, 1);
            chk("op_we", tlb_we, (op != 2'd0));
            if (op == 2'd0) chk("rd_index", tlb_r_index, idx);
            else if (op == 2'd1) chk("wr_index", tlb_w_index, idx);
            else begin
                chk("fill_index", tlb_w_index, cyc % TLBNUM);
                if (have_fill && tlb_w_index < last_fill) wrap_seen = 1;
                last_fill = tlb_w_index;
                have_fill = 1;
            end
            tick;
            @(negedge clk);
            chk("op_done", wb_done, 1);
            chk("op_we_once", tlb_we, 0);
            tick;
        end else begin
            lat = 0;
            for (int k = 1; k <= TLBNUM + 6; k++) begin
                @(negedge clk);
                if (tlb_inv_clr) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1F;
                    chk("inv_clr_idx", {1'b0, tlb_r_index}, e);
                    clr_obs.push_back(tlb_r_index);
                end
                if (wb_done) begin
                    lat = k;
                    break;
                end
                tick;
            end
            chk("inv_latency", lat, (iop > 5'd6) ? 2 : TLBNUM + 2);
            chk("inv_missed", exp_q.size(), 0);
            tick;
            foreach (clr_obs[j]) te[clr_obs[j]] = 1'b0;
        end
    endtask

    task automatic do_srch(input logic found, input logic [3:0] idx, input logic flush_it);
        ex_srch_valid = 1'b1;
        @(negedge clk);
        chk("srch_ready", ex_srch_ready, 1);
        tick;
        ex_srch_valid = 1'b0;
        tlb_s_found = found; tlb_s_index = idx; flush = flush_it;
        @(negedge clk);
        chk("srch_s_req", tlb_s_req, 1);
        tick;
        flush = 1'b0;
        tlb_s_found = 1'($urandom); tlb_s_index = 4'($urandom);
        if (!flush_it) begin
            exp_found = found;
            exp_idx = idx;
        end
        @(negedge clk);
        chk("srch_done", ex_srch_done, !flush_it);
        chk("srch_found", ex_srch_found, exp_found);
        chk("srch_index", ex_srch_index, exp_idx);
        chk("srch_busy", busy, !flush_it);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, stray;
        for (int i = 0; i < TLBNUM; i++) begin
            te[i] = 1'b1; tg[i] = 1'b0; tasid[i] = 10'h0; tvppn[i] = 19'h0;
        end

        // reset: everything quiet even with requests pending
        wb_req_valid = 1'b1; ex_srch_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_wb_ready", wb_req_ready, 0);
        chk("rst_srch_ready", ex_srch_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", tlb_we, 0);
        chk("rst_s_req", tlb_s_req, 0);
        chk("rst_inv_clr", tlb_inv_clr, 0);
        chk("rst_done", {wb_done, ex_srch_done}, 0);
        chk("rst_found", {ex_srch_found, ex_srch_index}, 0);
        chk("rst_idx", {tlb_r_index, tlb_w_index}, 0);
        wb_req_valid = 1'b0; ex_srch_valid = 1'b0;
        resetn = 1'b1;
        tick;

        do_wb(2'd1, 4'd5, 5'd0, 10'd0, 19'd0);
        do_wb(2'd0, 4'd11, 5'd0, 10'd0, 19'd0);

        // WB and EXE together: WB wins, search waits for IDLE
        wb_req_valid = 1'b1; wb_req_op = 2'd0; csr_tlbidx_index = 4'd7; ex_srch_valid = 1'b1;
        @(negedge clk);
        chk("both_wb_ready", wb_req_ready, 1);
        chk("both_srch_ready0", ex_srch_ready, 0);
        tick;
        wb_req_valid = 1'b0;
        @(negedge clk);
        chk("both_srch_ready1", ex_srch_ready, 0);
        chk("both_rd_index", tlb_r_index, 7);
        tick;
        @(negedge clk);
        chk("both_srch_ready2", ex_srch_ready, 0);
        chk("both_wb_done", wb_done, 1);
        tick;
        do_srch(1'b1, 4'd3, 1'b0);

        do_srch(1'b1, 4'd9, 1'b0);
        do_srch(1'b0, 4'd6, 1'b0);

        // search blocked by ASID/EHI writes and by flush
        ex_srch_valid = 1'b1; wb_write_asid_ehi = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ehi_block", {ex_srch_ready, busy}, 0);
            tick;
        end
        wb_write_asid_ehi = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("flush_block", {ex_srch_ready, busy}, 0);
        tick;
        flush = 1'b0; ex_srch_valid = 1'b0;

        do_srch(1'b0, 4'd4, 1'b1);
        do_srch(1'b1, 4'd12, 1'b1);

        // INVTLB op5: only entries 2 and 14 qualify
        for (int i = 0; i < TLBNUM; i++) begin
            te[i] = 1'b1; tg[i] = 1'b0; tasid[i] = 10'h3; tvppn[i] = 19'h1000 + 19'(i);
        end
        tvppn[2] = 19'h5A5A5; tvppn[14] = 19'h5A5A5;
        tvppn[5] = 19'h5A5A5; tg[5] = 1'b1;
        tvppn[7] = 19'h5A5A5; tasid[7] = 10'h4;
        do_wb(2'd3, 4'd0, 5'd5, 10'h3, 19'h5A5A5);
        chk("inv5_count", clr_obs.size(), 2);
        if (clr_obs.size() == 2) begin
            chk("inv5_first", clr_obs[0], 2);
            chk("inv5_second", clr_obs[1], 14);
        end
        do_wb(2'd3, 4'd0, 5'd9, 10'h3, 19'h5A5A5);

        // back-to-back TLBFILL across the counter wrap
        have_fill = 0; wrap_seen = 0;
        repeat (8) do_wb(2'd2, 4'($urandom), 5'd0, 10'd0, 19'd0);
        chk("fill_wrap", wrap_seen, 1);

        for (int n = 0; n < 24; n++) begin
            rand_table();
            r = $urandom_range(0, 4);
            if (r == 4)
                do_srch(1'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));
            else if (r == 3)
                do_wb(2'd3, 4'($urandom), 5'($urandom_range(0, 7)), 10'($urandom_range(1, 3)),
                      19'h100 + 19'($urandom_range(0, 1)));
            else
                do_wb(2'(r), 4'($urandom), 5'd0, 10'd0, 19'd0);
        end

        // reset in the middle of an INVTLB that clears every entry
        for (int i = 0; i < TLBNUM; i++) te[i] = 1'b1;
        wb_req_valid = 1'b1; wb_req_op = 2'd3; wb_inv_op = 5'd0;
        @(negedge clk);
        chk("mid_wb_ready", wb_req_ready, 1);
        tick;
        wb_req_valid = 1'b0;
        repeat (5) tick;
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_clr", tlb_inv_clr, 0);
        chk("mid_rst_done", wb_done, 0);
        chk("mid_rst_found", {ex_srch_found, ex_srch_index}, 0);
        exp_found = 1'b0; exp_idx = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        tick;
        stray = 0;
        repeat (25) begin
            @(negedge clk);
            if (wb_done || tlb_we || tlb_inv_clr || busy) stray++;
            tick;
        end
        chk("mid_rst_stray", stray, 0);
        do_srch(1'b1, 4'd10, 1'b0);

        chk("port_exclusive", excl_viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tlb_op_sched.md
TLB_OP_SCHED -- requirements
Module: tlb_op_sched

Interface
REQ-001 Parameter TLBNUM, default 16, number of TLB entries; index width 4 (log2 TLBNUM).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 wb_req_valid  in  1  WB-stage TLB instruction pending.
REQ-005 wb_req_op  in  2  0=TLBRD, 1=TLBWR, 2=TLBFILL, 3=INVTLB.
REQ-006 wb_inv_op  in  5  INVTLB op field; wb_inv_asid  in  10; wb_inv_vppn  in  19.
REQ-007 wb_req_ready  out  1  WB request accepted this cycle; wb_done  out  1  one-cycle completion pulse.
REQ-008 ex_srch_valid  in  1  EXE TLBSRCH request; ex_srch_ready  out  1  accepted this cycle.
REQ-009 ex_srch_done  out  1  pulse; ex_srch_found  out  1; ex_srch_index  out  4; hold value until next search completes.
REQ-010 wb_write_asid_ehi  in  1  WB writing ASID/TLBEHI; flush  in  1  WB exception/ertn/refetch.
REQ-011 csr_tlbidx_index  in  4  TLBIDX.INDEX.
REQ-012 tlb_s_req  out  1  drive TLB search port; tlb_s_found  in  1; tlb_s_index  in  4.
REQ-013 tlb_r_index  out  4; tlb_r_e, tlb_r_g  in  1 each; tlb_r_asid  in  10; tlb_r_vppn  in  19 (combinational read port).
REQ-014 tlb_we  out  1; tlb_w_index  out  4; tlb_inv_clr  out  1 clear E bit of tlb_r_index; busy  out  1  state != IDLE.

Function
REQ-015 States IDLE, SRCH, RD, WR, INV, DONE; encoded register, one state per cycle.
REQ-016 IDLE: wb_req_valid has priority; wb_req_ready = IDLE & wb_req_valid; next state RD/WR/WR/INV per op.
REQ-017 ex_srch_ready = IDLE & ~wb_req_valid & ~wb_write_asid_ehi & ~flush & ex_srch_valid; next state SRCH.
REQ-018 SRCH: tlb_s_req=1 one cycle; tlb_s_found/tlb_s_index registered into ex_srch_found/index at exit; next DONE.
REQ-019 ex_srch_done pulses in DONE after SRCH: accept edge N, done visible cycle N+2.
REQ-020 flush while in SRCH: abort to IDLE, no register update, no ex_srch_done.
REQ-021 flush never aborts RD, WR or INV (request originates in WB).
REQ-022 RD: tlb_r_index=csr_tlbidx_index one cycle; next DONE; wb_done pulses in DONE.
REQ-023 WR: tlb_we=1 exactly one cycle; tlb_w_index=csr_tlbidx_index for TLBWR, fill_ctr for TLBFILL; next DONE.
REQ-024 fill_ctr: 4-bit free-running, +1 every cycle, wraps 15->0; value sampled in the WR cycle.
REQ-025 INV: scan_ctr from 0 to TLBNUM-1, one entry per cycle, tlb_r_index=scan_ctr.
REQ-026 INV match (with tlb_r_e=1): op0/op1 all; op2 g=1; op3 g=0; op4 g=0 & asid eq; op5 g=0 & asid eq & vppn eq; op6 (g=1 | asid eq) & vppn eq.
REQ-027 tlb_inv_clr=1 in scan cycle on match; after scan_ctr=TLBNUM-1 go DONE; scan_ctr clears to 0.
REQ-028 wb_inv_op>6: no clears, INV lasts one cycle, then DONE (exception raised upstream).
REQ-029 DONE: pulses wb_done or ex_srch_done as per origin, returns IDLE; no accept in DONE.
REQ-030 Op/inv fields latched at accept; inputs may change afterward.
REQ-031 tlb_we, tlb_s_req, tlb_inv_clr never asserted in same cycle.
REQ-032 INVTLB latency TLBNUM+2 cycles accept-to-done; RD/WR 2; SRCH 2.

Reset
REQ-033 resetn low: immediate state IDLE; fill_ctr, scan_ctr 0; all outputs 0; ex_srch_found/index 0.
REQ-034 Reset mid-operation: operation dropped, no done pulse, no further tlb_we/tlb_inv_clr.

Verification
REQ-035 TLBWR idx=5: wb_req_ready cycle N, tlb_we=1 w_index=5 cycle N+1, wb_done N+2.
REQ-036 Simultaneous wb_req_valid (TLBRD) and ex_srch_valid: WB accepted, ex_srch_ready=0 until IDLE regained; search then completes with done.
REQ-037 TLBSRCH hit entry 9: ex_srch_found=1, index=9 at N+2; with wb_write_asid_ehi=1, ex_srch_ready held 0.
REQ-038 INVTLB op5 asid=0x3, vppn match only in entries 2,14 (g=0): tlb_inv_clr exactly at scan 2,14; wb_done at N+18.
REQ-039 flush during SRCH: no ex_srch_done, found/index unchanged, IDLE next cycle; resetn low mid-INV: busy=0 immediately.
REQ-040 TLBFILL back-to-back: w_index equals fill_ctr sample, wrap 15->0 observed.
